// File: rtl/conv_wm_pingpong_buf.sv
// Double-buffered convolution weight memory: the loader fills one bank while
// the conv engine reads the other, with bank ownership tracked by full flags.
module conv_wm_pingpong_buf #(
  parameter int DATA_W       = 512,
  parameter int DEPTH        = 576,
  parameter int ADDR_W       = 10,
  parameter int READ_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_last,
  output logic              wr_ready,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ready,
  input  logic              rd_release,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [1:0]        bank_full,
  output logic [1:0]        err
);

  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];

  logic [DATA_W-1:0] mem [0:1][0:DEPTH-1];

  logic              wr_bank;
  logic              rd_bank;
  logic [1:0]        full;
  logic [1:0]        full_nxt;
  logic [1:0]        err_r;
  logic [READ_LATENCY-1:0] vld;
  logic [DATA_W-1:0] pipe [0:READ_LATENCY-1];

  logic              wr_in_range;
  logic              rd_in_range;
  logic              wr_acc;
  logic              rd_acc;
  logic              rel_acc;
  logic              wr_drop;
  logic              rd_drop;
  logic              rel_drop;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;

  assign wr_ready    = !full[wr_bank];
  assign rd_ready    = full[rd_bank];

  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_C);
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_C);

  // Reset dominates: nothing is accepted or flagged while rst_n is low.
  assign wr_acc   = rst_n & wr_en & wr_ready & wr_in_range;
  assign rd_acc   = rst_n & rd_en & rd_ready & rd_in_range;
  assign rel_acc  = rst_n & rd_release & rd_ready;
  assign wr_drop  = rst_n & wr_en & !(wr_ready & wr_in_range);
  assign rd_drop  = rst_n & rd_en & !(rd_ready & rd_in_range);
  assign rel_drop = rst_n & rd_release & !rd_ready;

  assign wr_idx   = wr_addr[IDX_W-1:0];
  assign rd_idx   = rd_addr[IDX_W-1:0];

  // Write and release always address different banks, so both may land together.
  always_comb begin
    full_nxt = full;
    if (wr_acc && wr_last) full_nxt[wr_bank] = 1'b1;
    if (rel_acc)           full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_bank][wr_idx] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      full    <= 2'b00;
      err_r   <= 2'b00;
    end else begin
      full  <= full_nxt;
      err_r <= err_r | {rd_drop | rel_drop, wr_drop};
      if (wr_acc && wr_last) wr_bank <= ~wr_bank;
      if (rel_acc)           rd_bank <= ~rd_bank;
    end
  end

  // Stage 0 samples the array at the accepting edge; later stages only move
  // on a valid token so rd_data holds between bursts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld <= '0;
      for (int i = 0; i < READ_LATENCY; i++) pipe[i] <= '0;
    end else begin
      vld[0] <= rd_acc;
      if (rd_acc) pipe[0] <= mem[rd_bank][rd_idx];
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld[i] <= vld[i-1];
        if (vld[i-1]) pipe[i] <= pipe[i-1];
      end
    end
  end

  assign rd_data   = pipe[READ_LATENCY-1];
  assign rd_valid  = vld[READ_LATENCY-1];
  assign bank_full = full;
  assign err       = err_r;

endmodule

// File: tb/tb_conv_wm_pingpong_buf.sv
// Scoreboard bench for conv_wm_pingpong_buf: three builds (latency 1, 2, 4)
// share one stimulus stream and are checked against a bank-level model.
module tb_conv_wm_pingpong_buf;

  localparam int DATA_W = 512;
  localparam int DEPTH  = 576;
  localparam int ADDR_W = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n = 1'b0;
  logic              wr_en = 1'b0, wr_last = 1'b0, rd_en = 1'b0, rd_release = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0, rd_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;

  logic              rdv [3];
  logic [DATA_W-1:0] rdd [3];
  logic              wrr [3];
  logic              rdr [3];
  logic [1:0]        bf  [3];
  logic [1:0]        er  [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    conv_wm_pingpong_buf #(
      .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
      .READ_LATENCY((g == 0) ? 1 : ((g == 1) ? 2 : 4))
    ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_last(wr_last),
      .wr_ready(wrr[g]),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_ready(rdr[g]), .rd_release(rd_release),
      .rd_data(rdd[g]), .rd_valid(rdv[g]),
      .bank_full(bf[g]), .err(er[g])
    );
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
  endfunction

  function automatic logic [DATA_W-1:0] rnd_word();
    logic [DATA_W-1:0] w;
    for (int i = 0; i < DATA_W / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // Reference model: bank contents, ownership and sticky errors.
  logic [DATA_W-1:0] mm [2][DEPTH];
  bit                mfull [2] = '{1'b0, 1'b0};
  bit                mwb = 1'b0, mrb = 1'b0;
  bit [1:0]          merr = 2'b00;
  bit                started = 1'b0, final_chk = 1'b0;
  int                cyc = 0;
  int                wptr = 0;

  typedef struct {
    logic [DATA_W-1:0] d;
    int                due;
  } sb_t;
  sb_t sbq [3][$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic do_cycle(input bit we, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                          input bit wl, input bit re, input logic [ADDR_W-1:0] ra, input bit rel,
                          input bit rst, output bit wacc);
    bit racc, relacc, owb, orb;
    logic [DATA_W-1:0] rdat;
    rst_n = !rst; wr_en = we; wr_addr = wa; wr_data = wd; wr_last = wl;
    rd_en = re; rd_addr = ra; rd_release = rel;
    wacc   = !rst && we && !mfull[mwb] && (int'(wa) < DEPTH);
    racc   = !rst && re && mfull[mrb] && (int'(ra) < DEPTH);
    relacc = !rst && rel && mfull[mrb];
    rdat   = racc ? mm[mrb][ra] : '0;
    @(posedge clk); #1;
    if (rst) begin
      mfull = '{1'b0, 1'b0}; mwb = 1'b0; mrb = 1'b0; merr = 2'b00;
    end else begin
      if (wacc) mm[mwb][wa] = wd;
      if (we && !wacc) merr[0] = 1'b1;
      if ((re && !racc) || (rel && !relacc)) merr[1] = 1'b1;
      owb = mwb; orb = mrb;
      if (wacc && wl) begin mfull[owb] = 1'b1; mwb = !owb; end
      if (relacc)     begin mfull[orb] = 1'b0; mrb = !orb; end
      if (racc)
        for (int k = 0; k < 3; k++) sbq[k].push_back('{d: rdat, due: cyc + lat_of(k) - 1});
    end
  endtask

  task automatic idle(input int n);
    bit ok;
    repeat (n) do_cycle(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, ok);
  endtask

  task automatic do_reset(input int n);
    bit ok;
    repeat (n) do_cycle(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1, ok);
    wptr = 0;
  endtask

  task automatic fill_bank(input bit pattern, input int base);
    bit ok;
    for (int i = 0; i < DEPTH; i++)
      do_cycle(1'b1, ADDR_W'(i), pattern ? DATA_W'(i + base) : rnd_word(),
               (i == DEPTH - 1), 1'b0, '0, 1'b0, 1'b0, ok);
  endtask

  // Monitor: owns every comparison and the counters.
  int                n_cmp = 0, n_fail = 0;
  logic [DATA_W-1:0] last_d [3] = '{'0, '0, '0};
  bit                rst_prev = 1'b0;
  sb_t               e;

  always @(negedge clk) begin
    if (final_chk) begin
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (sbq[k].size() != 0) begin
          n_fail++;
          $display("FAIL drain_lat%0d: %0d reads outstanding, required 0", lat_of(k), sbq[k].size());
        end
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
    end else begin
      if (rst_prev)
        for (int k = 0; k < 3; k++) begin sbq[k].delete(); last_d[k] = '0; end
      rst_prev = !rst_n;
      if (started) begin
        for (int k = 0; k < 3; k++) begin
          n_cmp++;
          if ({wrr[k], rdr[k], bf[k], er[k]} !== {!mfull[mwb], mfull[mrb], mfull[1], mfull[0], merr}) begin
            n_fail++;
            $display("FAIL flags_lat%0d cyc %0d: got wr_ready=%b rd_ready=%b bank_full=%b err=%b, required %b %b %b%b %b",
                     lat_of(k), cyc, wrr[k], rdr[k], bf[k], er[k], !mfull[mwb], mfull[mrb], mfull[1], mfull[0], merr);
          end
          n_cmp++;
          if (rdv[k] === 1'b1) begin
            if (sbq[k].size() == 0) begin
              n_fail++;
              $display("FAIL unexpected_valid_lat%0d cyc %0d: rd_valid=1, required 0", lat_of(k), cyc);
            end else begin
              e = sbq[k].pop_front();
              if (e.due != cyc || rdd[k] !== e.d) begin
                n_fail++;
                $display("FAIL read_lat%0d cyc %0d: got data %h, required %h due cyc %0d",
                         lat_of(k), cyc, rdd[k], e.d, e.due);
              end
              last_d[k] = e.d;
            end
          end else begin
            if (rdd[k] !== last_d[k]) begin
              n_fail++;
              $display("FAIL hold_lat%0d cyc %0d: rd_data %h, required %h", lat_of(k), cyc, rdd[k], last_d[k]);
            end
            if (sbq[k].size() > 0 && sbq[k][0].due <= cyc) begin
              n_cmp++; n_fail++;
              e = sbq[k].pop_front();
              $display("FAIL missing_valid_lat%0d cyc %0d: rd_valid=%b, required 1 (due cyc %0d)",
                       lat_of(k), cyc, rdv[k], e.due);
            end
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    bit ok;
    @(posedge clk); #1;
    do_reset(1);
    started = 1'b1;
    do_reset(2);
    idle(3);

    // Fill bank0, then read it back-to-back while bank1 fills.
    fill_bank(1'b1, 0);
    for (int i = 0; i < DEPTH; i++)
      do_cycle(1'b1, ADDR_W'(i), DATA_W'(i + 1000), (i == DEPTH - 1),
               1'b1, ADDR_W'(i), 1'b0, 1'b0, ok);
    // Both full: dropped write with wr_last; then read+release, cross-bank read, out-of-range read.
    do_cycle(1'b1, ADDR_W'(10), DATA_W'(32'hdead), 1'b1, 1'b0, '0, 1'b0, 1'b0, ok);
    do_cycle(1'b0, '0, '0, 1'b0, 1'b1, ADDR_W'(3), 1'b1, 1'b0, ok);
    do_cycle(1'b0, '0, '0, 1'b0, 1'b1, ADDR_W'(5), 1'b0, 1'b0, ok);
    do_cycle(1'b0, '0, '0, 1'b0, 1'b1, ADDR_W'(600), 1'b0, 1'b0, ok);
    do_cycle(1'b1, '0, rnd_word(), 1'b0, 1'b0, '0, 1'b0, 1'b0, ok);
    wptr = ok ? 1 : 0;
    idle(6);

    for (int n = 0; n < 3000; n++) begin
      bit we, wl, re, rel;
      logic [ADDR_W-1:0] wa, ra;
      we  = ($urandom_range(0, 99) < 70);
      wa  = ($urandom_range(0, 19) == 0) ? ADDR_W'($urandom_range(DEPTH, (1 << ADDR_W) - 1)) : ADDR_W'(wptr);
      wl  = (int'(wa) == DEPTH - 1) || (int'(wa) >= DEPTH && $urandom_range(0, 9) == 0);
      re  = ($urandom_range(0, 99) < 60);
      ra  = ($urandom_range(0, 9) == 0) ? ADDR_W'($urandom_range(DEPTH, (1 << ADDR_W) - 1))
                                        : ADDR_W'($urandom_range(0, DEPTH - 1));
      rel = ($urandom_range(0, 99) < 3);
      do_cycle(we, wa, rnd_word(), wl, re, ra, rel, 1'b0, ok);
      if (ok) wptr = wl ? 0 : wptr + 1;
    end
    idle(6);

    // Reset mid-fill with reads in flight, then confirm loading restarts at bank0.
    do_reset(2);
    fill_bank(1'b0, 0);
    for (int i = 0; i < 100; i++)
      do_cycle(1'b1, ADDR_W'(i), rnd_word(), 1'b0, (i >= 98), ADDR_W'(i), 1'b0, 1'b0, ok);
    do_reset(1);
    idle(5);
    fill_bank(1'b1, 7);
    for (int i = 0; i < 8; i++)
      do_cycle(1'b0, '0, '0, 1'b0, 1'b1, ADDR_W'($urandom_range(0, DEPTH - 1)), 1'b0, 1'b0, ok);
    idle(8);
    final_chk = 1'b1;
  end

endmodule
